// File: rtl/uart_bus_master.sv
// UART (8N1) command bridge: host frames become single 32-bit bus transactions, replies go back on tx_pin.
// Optional inter-byte timeout in S_ADDR/S_DATA is built when UART_BUS_MASTER_TIMEOUT_EN is defined.
module uart_bus_master #(
   parameter logic [15:0] CLK_DIV      = 16'd434,
   parameter int          TIMEOUT_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_pin,
   output logic        tx_pin,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   output logic [3:0]  sel_o,
   output logic        we_o,
   output logic        req_valid_o,
   input  logic        req_ready_i,
   input  logic [31:0] data_i,
   input  logic        rsp_valid_i,
   output logic        rsp_ready_o,
   output logic        busy_o
);
   typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_REQ, S_RSP, S_TX} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam logic [15:0] HALF_DIV = CLK_DIV >> 1;

   logic        rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_t   rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        byte_ok, byte_err, tmo_hit;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  bit_q, bit_d;
   logic [2:0]  byte_q, byte_d, nbytes_q, nbytes_d;
   logic [31:0] tx_sh_q, tx_sh_d, addr_q, addr_d, data_q, data_d;
   logic        we_q, we_d, tx_pin_q, tx_pin_d;
   logic [7:0]  tx_lsb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_q  <= 1'b1;
         rx_s2_q  <= 1'b1;
         rx_s3_q  <= 1'b1;
         rx_st_q  <= RX_IDLE;
         rx_cnt_q <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
      end else begin
         rx_s1_q  <= rx_pin;
         rx_s2_q  <= rx_s1_q;
         rx_s3_q  <= rx_s2_q;
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
      end
   end

   // Stop-bit sample raises byte_ok/byte_err combinationally so the frame FSM reacts the same cycle.
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      byte_ok  = 1'b0;
      byte_err = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_st_d  = RX_START;
               rx_cnt_d = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_DIV) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
         end
         RX_DATA: begin
            if (rx_cnt_q == CLK_DIV) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 4'd1;
               if (rx_bit_q == 4'd7) rx_st_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
         end
         RX_STOP: begin
            if (rx_cnt_q == CLK_DIV) begin
               rx_cnt_d = '0;
               rx_st_d  = RX_IDLE;
               byte_ok  = rx_s2_q;
               byte_err = !rx_s2_q;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

`ifdef UART_BUS_MASTER_TIMEOUT_EN
   // Idle time is counted from the stop-bit sample, so half a bit is added to reach stop-bit end.
   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS) * (32'(CLK_DIV) + 32'd1) + 32'(HALF_DIV);
   logic [31:0] tmo_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else if ((state_q != S_ADDR && state_q != S_DATA) || rx_st_q != RX_IDLE) tmo_q <= '0;
      else if (tmo_q <= TMO_LIMIT) tmo_q <= tmo_q + 32'd1;
   end
   assign tmo_hit = (tmo_q > TMO_LIMIT);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_CMD;
         cnt_q    <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         nbytes_q <= '0;
         tx_sh_q  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         tx_pin_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         nbytes_q <= nbytes_d;
         tx_sh_q  <= tx_sh_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         tx_pin_q <= tx_pin_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      nbytes_d = nbytes_q;
      tx_sh_d  = tx_sh_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_d     = we_q;
      case (state_q)
         S_CMD: begin
            if (byte_ok) begin
               byte_d = '0;
               if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
                  we_d    = (rx_sh_q == 8'h57);
                  state_d = S_ADDR;
               end else begin
                  tx_sh_d  = 32'h0000_0015;
                  nbytes_d = 3'd1;
                  cnt_d    = '0;
                  bit_d    = '0;
                  state_d  = S_TX;
               end
            end
         end
         S_ADDR: begin
            if (byte_err) begin
               byte_d  = '0;
               state_d = S_CMD;
            end else if (byte_ok) begin
               addr_d = {rx_sh_q, addr_q[31:8]};
               byte_d = byte_q + 3'd1;
               if (byte_q == 3'd3) begin
                  byte_d  = '0;
                  state_d = we_q ? S_DATA : S_REQ;
               end
            end
         end
         S_DATA: begin
            if (byte_err) begin
               byte_d  = '0;
               state_d = S_CMD;
            end else if (byte_ok) begin
               data_d = {rx_sh_q, data_q[31:8]};
               byte_d = byte_q + 3'd1;
               if (byte_q == 3'd3) begin
                  byte_d  = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: if (req_ready_i) state_d = S_RSP;
         S_RSP: begin
            if (rsp_valid_i) begin
               cnt_d    = '0;
               bit_d    = '0;
               byte_d   = '0;
               state_d  = S_TX;
               tx_sh_d  = we_q ? 32'h0000_0006 : data_i;
               nbytes_d = we_q ? 3'd1 : 3'd4;
            end
         end
         S_TX: begin
            if (cnt_q == CLK_DIV) begin
               cnt_d = '0;
               if (bit_q == 4'd9) begin
                  bit_d   = '0;
                  tx_sh_d = tx_sh_q >> 8;
                  byte_d  = byte_q + 3'd1;
                  if (byte_q == nbytes_q - 3'd1) begin
                     byte_d  = '0;
                     state_d = S_CMD;
                  end
               end else bit_d = bit_q + 4'd1;
            end else cnt_d = cnt_q + 16'd1;
         end
         default: state_d = S_CMD;
      endcase
      if (tmo_hit && (state_q == S_ADDR || state_q == S_DATA)) begin
         byte_d  = '0;
         state_d = S_CMD;
      end
      // Line level is registered from next-state values so tx_pin is glitch-free.
      tx_lsb   = tx_sh_d[7:0];
      tx_pin_d = 1'b1;
      if (state_d == S_TX) begin
         if (bit_d == 4'd0) tx_pin_d = 1'b0;
         else if (bit_d <= 4'd8) tx_pin_d = tx_lsb[3'(bit_d - 4'd1)];
      end
   end

   assign tx_pin      = tx_pin_q;
   assign addr_o      = addr_q;
   assign data_o      = data_q;
   assign we_o        = we_q;
   assign sel_o       = 4'hf;
   assign req_valid_o = (state_q == S_REQ);
   assign rsp_ready_o = (state_q == S_RSP);
   assign busy_o      = (state_q != S_CMD);
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master at CLK_DIV=15 (16 cycles per bit) with a small bus slave and TX decoder.
`timescale 1ns/1ps
module tb_uart_bus_master;
   localparam int BITC = 16;

   logic        clk = 1'b0;
   logic        rst, rx_pin, tx_pin;
   logic [31:0] addr_o, data_o, data_i;
   logic [3:0]  sel_o;
   logic        we_o, req_valid_o, req_ready_i, rsp_valid_i, rsp_ready_o, busy_o;

   always #5 clk = ~clk;

   uart_bus_master #(.CLK_DIV(16'd15), .TIMEOUT_BITS(16)) dut (
      .clk(clk), .rst(rst), .rx_pin(rx_pin), .tx_pin(tx_pin),
      .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .data_i(data_i),
      .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .busy_o(busy_o)
   );

   int          total = 0, bad = 0;
   int          ready_delay = 0, rsp_delay = 0;
   logic [31:0] slave_rdata = 32'h0;
   int          nreq = 0, tx_stop_err = 0;
   logic [31:0] req_addr = 32'h0, req_data = 32'h0;
   logic        req_we = 1'b0;
   logic [3:0]  req_sel = 4'h0;
   logic [7:0]  txq[$];

   // Bus slave: optional ready stall, then a response after rsp_delay cycles.
   initial begin
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      data_i      = 32'h0;
      forever begin
         @(negedge clk);
         if (req_valid_o && !rst) begin
            repeat (ready_delay) @(negedge clk);
            req_ready_i = 1'b1;
            @(negedge clk);
            req_ready_i = 1'b0;
            repeat (rsp_delay) @(negedge clk);
            data_i      = slave_rdata;
            rsp_valid_i = 1'b1;
            for (int k = 0; k < 100 && !rsp_ready_o; k++) @(negedge clk);
            @(negedge clk);
            rsp_valid_i = 1'b0;
            data_i      = 32'h0;
         end
      end
   end

   always @(negedge clk) begin
      if (req_valid_o && req_ready_i) begin
         nreq     <= nreq + 1;
         req_addr <= addr_o;
         req_data <= data_o;
         req_we   <= we_o;
         req_sel  <= sel_o;
      end
   end

   // TX decoder sampling mid-bit at a nominal 16 cycles per bit.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge tx_pin);
         if (!rst) begin
            repeat (8) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
               repeat (BITC) @(posedge clk);
               #1 b[i] = tx_pin;
            end
            repeat (BITC) @(posedge clk);
            #1 if (!tx_pin) tx_stop_err++;
            txq.push_back(b);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stopv);
      @(negedge clk);
      rx_pin = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (BITC) @(negedge clk);
      end
      rx_pin = stopv;
      repeat (BITC) @(negedge clk);
      rx_pin = 1'b1;
      if (!stopv) repeat (BITC) @(negedge clk);
   endtask

   task automatic send_write(input logic [31:0] a, input logic [31:0] d);
      send_byte(8'h57, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
   endtask

   task automatic send_read(input logic [31:0] a);
      send_byte(8'h52, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
   endtask

   task automatic wait_done(input int n);
      for (int k = 0; k < 3000 && txq.size() < n; k++) @(negedge clk);
      for (int k = 0; k < 3000 && busy_o; k++) @(negedge clk);
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_pin = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (tx_pin !== 1'b1) begin bad++; $display("FAIL reset_tx_pin got=%b want=1", tx_pin); end
      total++; if (req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", req_valid_o); end
      total++; if (rsp_ready_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready got=%b want=0", rsp_ready_o); end
      total++; if (we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we_o); end
      total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", addr_o); end
      total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (sel_o !== 4'hf) begin bad++; $display("FAIL reset_sel got=%h want=f", sel_o); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (tx_pin !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_idle tx=%b busy=%b want tx=1 busy=0", tx_pin, busy_o); end
   endtask

   task automatic test_write();
      int n0, lowcnt;
      n0 = nreq;
      lowcnt = 0;
      txq.delete();
      fork
         send_write(32'h8000_1000, 32'hDEAD_BEEF);
         begin
            for (int k = 0; k < 4000 && tx_pin; k++) begin @(posedge clk); #1; end
            for (int k = 0; k < 100 && !tx_pin; k++) begin @(posedge clk); #1 lowcnt++; end
         end
      join
      wait_done(1);
      total++; if (nreq - n0 != 1) begin bad++; $display("FAIL write_req_count got=%0d want=1", nreq - n0); end
      total++; if (req_addr !== 32'h8000_1000) begin bad++; $display("FAIL write_addr got=%h want=80001000", req_addr); end
      total++; if (req_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_data got=%h want=deadbeef", req_data); end
      total++; if (req_we !== 1'b1 || req_sel !== 4'hf) begin bad++; $display("FAIL write_we_sel got=%b/%h want=1/f", req_we, req_sel); end
      // 0x06 LSB first: start bit plus d0 give 32 low cycles.
      total++; if (lowcnt != 32) begin bad++; $display("FAIL write_tx_bit_time got=%0d want=32", lowcnt); end
      total++; if (txq.size() != 1 || txq[0] !== 8'h06) begin bad++; $display("FAIL write_ack got_n=%0d got=%h want=06", txq.size(), (txq.size() > 0) ? txq[0] : 8'h00); end
      total++; if (tx_stop_err != 0 || busy_o !== 1'b0) begin bad++; $display("FAIL write_idle stop_err=%0d busy=%b want 0/0", tx_stop_err, busy_o); end
   endtask

   task automatic test_read();
      int n0;
      logic [7:0] exp_b[4];
      exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
      n0 = nreq;
      txq.delete();
      rsp_delay = 3;
      slave_rdata = 32'h1234_5678;
      send_read(32'h2000_0004);
      wait_done(4);
      rsp_delay = 0;
      total++; if (nreq - n0 != 1) begin bad++; $display("FAIL read_req_count got=%0d want=1", nreq - n0); end
      total++; if (req_addr !== 32'h2000_0004 || req_we !== 1'b0) begin bad++; $display("FAIL read_addr_we got=%h/%b want=20000004/0", req_addr, req_we); end
      total++; if (txq.size() != 4) begin bad++; $display("FAIL read_tx_count got=%0d want=4", txq.size()); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (((i < txq.size()) ? txq[i] : 8'hxx) !== exp_b[i]) begin
            bad++; $display("FAIL read_byte%0d got=%h want=%h", i, (i < txq.size()) ? txq[i] : 8'h00, exp_b[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n0;
      logic [31:0] a0, d0;
      n0 = nreq;
      txq.delete();
      ready_delay = 10;
      fork
         send_write(32'h0000_0100, 32'hCAFE_F00D);
         begin
            for (int k = 0; k < 3000 && !req_valid_o; k++) @(negedge clk);
            a0 = addr_o;
            d0 = data_o;
            total++; if (req_valid_o !== 1'b1) begin bad++; $display("FAIL bp_req_seen got=%b want=1", req_valid_o); end
            for (int i = 0; i < 9; i++) begin
               @(negedge clk);
               total++;
               if (req_valid_o !== 1'b1 || addr_o !== a0 || data_o !== d0 || nreq != n0) begin
                  bad++; $display("FAIL bp_hold cyc=%0d valid=%b addr=%h data=%h nreq=%0d want 1/%h/%h/%0d", i, req_valid_o, addr_o, data_o, nreq - n0, a0, d0, 0);
               end
            end
         end
      join
      wait_done(1);
      ready_delay = 0;
      total++; if (nreq - n0 != 1) begin bad++; $display("FAIL bp_req_count got=%0d want=1", nreq - n0); end
      total++; if (req_addr !== 32'h0000_0100 || req_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL bp_payload got=%h/%h want=00000100/cafef00d", req_addr, req_data); end
      total++; if (txq.size() != 1 || txq[0] !== 8'h06) begin bad++; $display("FAIL bp_ack got_n=%0d want 1 byte 06", txq.size()); end
   endtask

   task automatic test_nak();
      int n0;
      n0 = nreq;
      txq.delete();
      send_byte(8'h41, 1'b1);
      wait_done(1);
      total++; if (nreq != n0) begin bad++; $display("FAIL nak_no_req got=%0d want=0", nreq - n0); end
      total++; if (txq.size() != 1 || txq[0] !== 8'h15) begin bad++; $display("FAIL nak_byte got_n=%0d got=%h want=15", txq.size(), (txq.size() > 0) ? txq[0] : 8'h00); end
      txq.delete();
      send_write(32'h0000_0010, 32'h0BAD_F00D);
      wait_done(1);
      total++; if (nreq - n0 != 1 || req_addr !== 32'h0000_0010 || req_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL nak_recover n=%0d addr=%h data=%h want 1/00000010/0badf00d", nreq - n0, req_addr, req_data); end
      total++; if (txq.size() != 1 || txq[0] !== 8'h06) begin bad++; $display("FAIL nak_recover_ack got_n=%0d want 1 byte 06", txq.size()); end
   endtask

   task automatic test_framing();
      int n0;
      n0 = nreq;
      txq.delete();
      send_byte(8'h57, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b0);
      repeat (300) @(negedge clk);
      total++; if (nreq != n0 || txq.size() != 0) begin bad++; $display("FAIL frame_err_quiet nreq=%0d tx=%0d want 0/0", nreq - n0, txq.size()); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL frame_err_busy got=%b want=0", busy_o); end
      slave_rdata = 32'hA5A5_5A5A;
      send_read(32'h2000_0004);
      wait_done(4);
      total++; if (nreq - n0 != 1 || req_addr !== 32'h2000_0004 || req_we !== 1'b0) begin bad++; $display("FAIL frame_recover n=%0d addr=%h we=%b want 1/20000004/0", nreq - n0, req_addr, req_we); end
      total++;
      if (txq.size() != 4 || txq[0] !== 8'h5A || txq[1] !== 8'h5A || txq[2] !== 8'hA5 || txq[3] !== 8'hA5) begin
         bad++; $display("FAIL frame_recover_data got_n=%0d want bytes 5a 5a a5 a5", txq.size());
      end
   endtask

   task automatic test_gap();
      int n0;
      n0 = nreq;
      txq.delete();
      send_byte(8'h57, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (17 * BITC) @(negedge clk);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL gap_abort_busy got=%b want=0", busy_o); end
      slave_rdata = 32'h0102_0304;
      send_read(32'h0000_0040);
      wait_done(4);
      total++; if (nreq - n0 != 1 || req_addr !== 32'h0000_0040 || req_we !== 1'b0) begin bad++; $display("FAIL gap_fresh_read n=%0d addr=%h we=%b want 1/00000040/0", nreq - n0, req_addr, req_we); end
      total++; if (txq.size() != 4 || txq[0] !== 8'h04 || txq[3] !== 8'h01) begin bad++; $display("FAIL gap_fresh_data got_n=%0d want bytes 04 03 02 01", txq.size()); end
`else
      total++; if (busy_o !== 1'b1 || nreq != n0) begin bad++; $display("FAIL gap_wait busy=%b nreq=%0d want 1/0", busy_o, nreq - n0); end
      send_byte(8'h20, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h40, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      wait_done(1);
      total++; if (nreq - n0 != 1 || req_addr !== 32'h4000_2000 || req_data !== 32'h4433_2211 || req_we !== 1'b1) begin bad++; $display("FAIL gap_write n=%0d addr=%h data=%h we=%b want 1/40002000/44332211/1", nreq - n0, req_addr, req_data, req_we); end
      total++; if (txq.size() != 1 || txq[0] !== 8'h06) begin bad++; $display("FAIL gap_ack got_n=%0d want 1 byte 06", txq.size()); end
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_nak();
      test_framing();
      test_gap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
